// File: rtl/hnf_arb_pkg.sv
// hnf_arb_pkg: state encodings shared by HNF arbiters
package hnf_arb_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
endpackage

// File: rtl/hnf_rr_pick.sv
// hnf_rr_pick: first set request at or after start, wrapping modulo N
module hnf_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);
  always_comb begin
    int j;
    logic found;
    found = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      j = (j >= N) ? j - N : j;
      if (!found && req[j]) begin
        found = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    any_req = |req;
    gnt = found ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/hnf_fifo_arb.sv
// hnf_fifo_arb: burst-limited round-robin drain of N source FIFOs into one output register
module hnf_fifo_arb
  import hnf_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            src_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_rd_data,
  output logic [NUM_REQ-1:0]            src_rd_en,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  input  logic                          out_ready
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d, start, pick_idx, w;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         src_q, src_d;
  logic [NUM_REQ-1:0]    req, pick_gnt;
  logic                  load_en, any_req, keep, pop;
  assign req     = ~src_empty;
  assign load_en = ~valid_q | out_ready;
  assign start   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  hnf_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (req),
    .start   (start),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );
  // the owner keeps the grant until its burst budget is spent or it runs dry
  assign keep = (state_q == ST_BURST) && req[owner_q] && (cnt_q < CW'(MAX_BURST));
  assign w    = keep ? owner_q : pick_idx;
  assign pop  = load_en & any_req & ~rst;
  assign src_rd_en = pop ? NUM_REQ'(1) << w : '0;
  always_comb begin
    state_d = pop ? ST_BURST : load_en ? ST_IDLE : state_q;
    owner_d = pop ? w : owner_q;
    cnt_d   = pop ? (keep ? cnt_q + 1'b1 : CW'(1)) : load_en ? '0 : cnt_q;
    valid_d = load_en ? pop : valid_q;
    data_d  = pop ? src_rd_data[w*DATA_WIDTH +: DATA_WIDTH] : data_q;
    src_d   = pop ? w : src_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
endmodule

// File: tb/tb_hnf_fifo_arb.sv
// tb_hnf_fifo_arb: randomized scoreboard bench against a queue-based arbitration model
module tb_hnf_fifo_arb;
  localparam int N = 4, DW = 32, MB = 4;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0, out_valid;
  logic [N-1:0] src_empty = '1, src_rd_en;
  logic [N*DW-1:0] src_rd_data = '0;
  logic [DW-1:0] out_data;
  logic [1:0] out_src;
  int total = 0, bad = 0;
  int m_owner, m_cnt;
  bit m_act, m_valid;
  logic [DW+1:0] sb[$];
  hnf_fifo_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_rd_data(src_rd_data),
    .src_rd_en(src_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("out_src", out_src, e[DW+1:DW]);
        chk("out_data", out_data, e[DW-1:0]);
      end
    end
  end
  task automatic step(input logic [N-1:0] emp, input logic rdy);
    logic [N-1:0] rq;
    int w;
    @(posedge clk); #1;
    src_empty = emp;
    out_ready = rdy;
    for (int i = 0; i < N; i++) src_rd_data[i*DW +: DW] = $urandom;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    rq = ~emp;
    if ((!m_valid || rdy) && rq != 0) begin
      if (m_act && rq[m_owner] && m_cnt < MB) begin
        w = m_owner;
        m_cnt++;
      end else begin
        w = -1;
        for (int k = 1; k <= N; k++) if (w < 0 && rq[(m_owner + k) % N]) w = (m_owner + k) % N;
        m_cnt = 1;
      end
      chk("src_rd_en", src_rd_en, 1 << w);
      sb.push_back({2'(w), src_rd_data[w*DW +: DW]});
      m_owner = w;
      m_act = 1;
      m_valid = 1;
    end else begin
      chk("src_rd_en_zero", src_rd_en, 0);
      if (!m_valid || rdy) begin
        m_valid = 0;
        m_act = 0;
        m_cnt = 0;
      end
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    src_empty = '0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_src_rd_en", src_rd_en, 0);
    src_empty = '1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_owner = N - 1;
    m_cnt = 0;
    m_act = 0;
    m_valid = 0;
  endtask
  initial begin
    do_reset();
    repeat (8) step(4'b1011, 1'b1);
    do_reset();
    repeat (17) step(4'b0000, 1'b1);
    repeat (5) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    do_reset();
    repeat (2) step(4'b0100, 1'b1);
    repeat (5) step(4'b0101, 1'b1);
    repeat (3) step(4'b1111, 1'b1);
    step(4'b1101, 1'b1);
    repeat (2) step(4'b1111, 1'b1);
    repeat (2) step(4'b0111, 1'b1);
    repeat (3) step(4'b1011, 1'b1);
    do_reset();
    repeat (3) step(4'b0000, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(($urandom_range(0, 3) == 0) ? 4'($urandom) | 4'b1100 : 4'($urandom),
           $urandom_range(0, 3) != 0);
    end
    repeat (3) step(4'b1111, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
